// File: rtl/rf_pkg.sv
// Shared constants and the writeback request type for the register-file
// write side.
package rf_pkg;

    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int DW    = 32;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// Synchronous FIFO for long-latency writeback results; the occupancy comes
// from read/write pointers that carry one extra wrap bit.
module rf_wb_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW:0]      r_wptr;
    logic [PW:0]      r_rptr;
    logic             w_push;
    logic             w_pop;

    assign o_level = r_wptr - r_rptr;
    assign o_full  = (o_level == (PW+1)'(DEPTH));
    assign o_empty = (o_level == '0);
    assign o_data  = r_mem[r_rptr[PW-1:0]];

    // Guard against over/underflow even if the caller misbehaves.
    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[PW-1:0]] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Drives the register file write port from the ALU path (always wins) and the
// buffered long-latency path, and tracks registers still awaiting writeback.
module rf_writeback_arbiter
    import rf_pkg::*;
#(
    parameter int NREGS      = rf_pkg::NREGS,
    parameter int AW         = rf_pkg::AW,
    parameter int DW         = rf_pkg::DW,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          a_valid,
    input  logic [AW-1:0]                 a_addr,
    input  logic [DW-1:0]                 a_data,
    input  logic                          b_valid,
    output logic                          b_ready,
    input  logic [AW-1:0]                 b_addr,
    input  logic [DW-1:0]                 b_data,
    input  logic                          set_v,
    input  logic [AW-1:0]                 set_addr,
    input  logic [AW-1:0]                 q1_addr,
    input  logic [AW-1:0]                 q2_addr,
    output logic                          busy1,
    output logic                          busy2,
    output logic                          we3,
    output logic [AW-1:0]                 wa3,
    output logic [DW-1:0]                 wd3,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    logic [AW+DW-1:0] w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_sel_vld;
    logic [AW-1:0]    w_sel_addr;
    logic [DW-1:0]    w_sel_data;
    logic [NREGS-1:0] r_pend;
    logic [NREGS-1:0] w_pend_nxt;

    assign b_ready = !w_full;
    assign w_push  = b_valid && b_ready;
    assign w_pop   = !a_valid && !w_empty;

    rf_wb_fifo #(
        .WIDTH (AW + DW),
        .DEPTH (FIFO_DEPTH)
    ) u_bfifo (
        .clk     (clk),
        .rst_n   (reset_n),
        .i_push  (w_push),
        .i_data  ({b_addr, b_data}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_level (fifo_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_sel_vld  = 1'b0;
        w_sel_addr = '0;
        w_sel_data = '0;
        if (a_valid) begin
            w_sel_vld  = 1'b1;
            w_sel_addr = a_addr;
            w_sel_data = a_data;
        end else if (w_pop) begin
            w_sel_vld  = 1'b1;
            w_sel_addr = w_head[AW+DW-1:DW];
            w_sel_data = w_head[DW-1:0];
        end
    end

    // Writes to register 0 still consume their slot but never reach the file.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we3 <= 1'b0;
            wa3 <= '0;
            wd3 <= '0;
        end else begin
            we3 <= w_sel_vld && (w_sel_addr != '0);
            wa3 <= w_sel_addr;
            wd3 <= w_sel_data;
        end
    end

    // A set on the same edge as the clear wins: the new producer is in flight.
    always_comb begin
        w_pend_nxt = r_pend;
        if (we3) begin
            w_pend_nxt[wa3] = 1'b0;
        end
        if (set_v && (set_addr != '0)) begin
            w_pend_nxt[set_addr] = 1'b1;
        end
        w_pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_nxt;
        end
    end

    assign busy1 = r_pend[q1_addr];
    assign busy2 = r_pend[q2_addr];

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Scoreboard bench for rf_writeback_arbiter: a small reference model predicts
// writes, FIFO level, b_ready and pending bits cycle by cycle.
module tb_rf_writeback_arbiter;
    import rf_pkg::*;

    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          a_valid;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_data;
    logic          b_valid;
    logic          b_ready;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_data;
    logic          set_v;
    logic [AW-1:0] set_addr;
    logic [AW-1:0] q1_addr;
    logic [AW-1:0] q2_addr;
    logic          busy1;
    logic          busy2;
    logic          we3;
    logic [AW-1:0] wa3;
    logic [DW-1:0] wd3;
    logic [2:0]    fifo_level;

    always #5 clk = ~clk;

    rf_writeback_arbiter #(
        .NREGS      (NREGS),
        .AW         (AW),
        .DW         (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .a_valid    (a_valid),
        .a_addr     (a_addr),
        .a_data     (a_data),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .b_addr     (b_addr),
        .b_data     (b_data),
        .set_v      (set_v),
        .set_addr   (set_addr),
        .q1_addr    (q1_addr),
        .q2_addr    (q2_addr),
        .busy1      (busy1),
        .busy2      (busy2),
        .we3        (we3),
        .wa3        (wa3),
        .wd3        (wd3),
        .fifo_level (fifo_level)
    );

    int checks = 0;
    int errors = 0;

    wb_req_t    m_fifo[$];
    wb_req_t    exp_q[$];
    logic [31:0] m_pend = '0;
    logic        m_we = 1'b0;
    logic [4:0]  m_wa = '0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        exp_q.delete();
        m_pend = '0;
        m_we   = 1'b0;
        m_wa   = '0;
    endtask

    task automatic idle_inputs();
        a_valid  = 1'b0; a_addr = '0; a_data = '0;
        b_valid  = 1'b0; b_addr = '0; b_data = '0;
        set_v    = 1'b0; set_addr = '0;
    endtask

    // One clock: predict from the inputs currently driven, clock, then compare.
    task automatic step();
        wb_req_t     sel;
        logic        sv;
        int          lvl0;
        logic [31:0] pend_nxt;
        wb_req_t     got;
        sel  = '0;
        sv   = 1'b0;
        lvl0 = m_fifo.size();
        check_eq("b_ready", b_ready, lvl0 != DEPTH);
        if (a_valid) begin
            sv = 1'b1; sel.addr = a_addr; sel.data = a_data;
        end else if (lvl0 > 0) begin
            sv = 1'b1; sel = m_fifo.pop_front();
        end
        if (b_valid && lvl0 < DEPTH) begin
            m_fifo.push_back('{addr: b_addr, data: b_data});
        end
        pend_nxt = m_pend;
        if (m_we) pend_nxt[m_wa] = 1'b0;
        if (set_v && set_addr != 0) pend_nxt[set_addr] = 1'b1;
        if (sv && sel.addr != 0) exp_q.push_back(sel);
        @(posedge clk);
        m_pend = pend_nxt;
        m_we   = sv && (sel.addr != 0);
        m_wa   = sel.addr;
        @(negedge clk);
        check_eq("we3", we3, m_we);
        if (we3) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_write", 1, 0);
            end else begin
                got = exp_q.pop_front();
                check_eq("wa3", wa3, got.addr);
                check_eq("wd3", wd3, got.data);
            end
        end
        check_eq("fifo_level", fifo_level, m_fifo.size());
        check_eq("busy1", busy1, m_pend[q1_addr]);
        check_eq("busy2", busy2, m_pend[q2_addr]);
    endtask

    initial begin
        int k;
        idle_inputs();
        q1_addr = '0; q2_addr = '0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_we3", we3, 0);
        check_eq("rst_level", fifo_level, 0);
        check_eq("rst_b_ready", b_ready, 1);
        reset_n = 1'b1;
        step();

        // ALU path with pending bit on register 5
        q1_addr = 5; q2_addr = 6;
        set_v = 1'b1; set_addr = 5;
        step();
        idle_inputs();
        step();
        check_eq("busy5_before", busy1, 1);
        a_valid = 1'b1; a_addr = 5; a_data = 32'hDEADBEEF;
        step();
        idle_inputs();
        check_eq("alu_we3", we3, 1);
        check_eq("alu_wd3", wd3, 32'hDEADBEEF);
        check_eq("busy5_during", busy1, 1);
        step();
        check_eq("busy5_after", busy1, 0);

        // Contention: A six cycles in a row while B offers 7..11
        q1_addr = 7; q2_addr = 11;
        k = 0;
        for (int i = 0; i < 6; i++) begin
            a_valid = 1'b1; a_addr = AW'(12 + i); a_data = $urandom;
            b_valid = (k < 5); b_addr = AW'(7 + k); b_data = 32'hB000_0000 + k;
            if (b_valid && m_fifo.size() < DEPTH) k++;
            step();
        end
        check_eq("contention_full", b_ready, 0);
        check_eq("contention_pushes", k, 4);
        a_valid = 1'b0;
        for (int i = 0; i < 20 && (k < 5 || m_fifo.size() > 0); i++) begin
            b_valid = (k < 5); b_addr = AW'(7 + k); b_data = 32'hB000_0000 + k;
            if (b_valid && m_fifo.size() < DEPTH) k++;
            step();
        end
        idle_inputs();
        step();
        check_eq("drain_done", fifo_level, 0);

        // Register zero: A and B results to r0, attempt to mark r0 pending
        q1_addr = 0; q2_addr = 0;
        a_valid = 1'b1; a_addr = 0; a_data = 32'h1111_1111;
        set_v = 1'b1; set_addr = 0;
        step();
        idle_inputs();
        b_valid = 1'b1; b_addr = 0; b_data = 32'h2222_2222;
        step();
        check_eq("r0_level_push", fifo_level, 1);
        idle_inputs();
        step();
        check_eq("r0_level_pop", fifo_level, 0);
        check_eq("r0_no_we", we3, 0);
        check_eq("r0_busy", busy1, 0);

        // Set/clear collision on register 3
        q1_addr = 3; q2_addr = 4;
        set_v = 1'b1; set_addr = 3;
        step();
        idle_inputs();
        a_valid = 1'b1; a_addr = 3; a_data = 32'h3333_0001;
        step();
        idle_inputs();
        set_v = 1'b1; set_addr = 3;
        check_eq("coll_we3", we3, 1);
        step();
        idle_inputs();
        check_eq("coll_busy3", busy1, 1);
        a_valid = 1'b1; a_addr = 3; a_data = 32'h3333_0002;
        step();
        idle_inputs();
        step();
        check_eq("coll_busy3_clr", busy1, 0);

        // Full/empty boundary
        q1_addr = 20; q2_addr = 24;
        for (int i = 0; i < 4; i++) begin
            a_valid = 1'b1; a_addr = 1; a_data = i;
            b_valid = 1'b1; b_addr = AW'(20 + i); b_data = 32'hF000_0000 + i;
            step();
        end
        check_eq("bnd_full_level", fifo_level, 4);
        check_eq("bnd_full_ready", b_ready, 0);
        a_valid = 1'b0;
        b_valid = 1'b1; b_addr = 24; b_data = 32'hF000_0024;
        step();
        check_eq("bnd_level3", fifo_level, 3);
        check_eq("bnd_ready_back", b_ready, 1);
        step();
        check_eq("bnd_push_level", fifo_level, 3);
        idle_inputs();
        for (int i = 0; i < 8 && m_fifo.size() > 0; i++) step();
        step();

        // Reset mid-stream with three buffered entries and pending bits
        set_v = 1'b1; set_addr = 26;
        for (int i = 0; i < 3; i++) begin
            a_valid = 1'b1; a_addr = 25; a_data = i;
            b_valid = 1'b1; b_addr = AW'(26 + i); b_data = i;
            step();
        end
        check_eq("pre_rst_level", fifo_level, 3);
        check_eq("pre_rst_busy", busy1, 0);
        reset_n = 1'b0;
        for (int r = 0; r < 2; r++) begin
            #1;
            check_eq("rstm_we3", we3, 0);
            check_eq("rstm_level", fifo_level, 0);
            check_eq("rstm_b_ready", b_ready, 1);
            for (int i = 0; i < NREGS; i++) begin
                q1_addr = AW'(i); q2_addr = AW'(NREGS - 1 - i);
                #1;
                check_eq("rstm_busy1", busy1, 0);
                check_eq("rstm_busy2", busy2, 0);
            end
            @(posedge clk);
            @(negedge clk);
        end
        idle_inputs();
        model_reset();
        reset_n = 1'b1;
        q1_addr = 26; q2_addr = 27;
        step();
        step();

        check_eq("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
